// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - front-panel run/edit controller for the HH:MM:SS counter chain
module clock_set_ctrl #(
    parameter logic [31:0] HOLD_CYC = 32'd50_000_000,
    parameter logic [31:0] RPT_CYC  = 32'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] sq0,
    input  logic [2:0] sq1,
    input  logic [3:0] mq0,
    input  logic [2:0] mq1,
    input  logic [3:0] hq0,
    input  logic [1:0] hq1,
    output logic       en,
    output logic       load,
    output logic [3:0] sd0,
    output logic [2:0] sd1,
    output logic [3:0] md0,
    output logic [2:0] md1,
    output logic [3:0] hd0,
    output logic [1:0] hd1,
    output logic [1:0] sel,
    output logic       blink
);

    typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} state_t;

    state_t      state, next_state;
    logic        mode_prev, inc_prev;
    logic        mode_press, inc_press;
    logic        in_set, rpt_fire, inc_fire;
    logic        repeating;
    logic [31:0] rpt_cnt;

    // Minutes/seconds step: anything at or above 59 wraps to 00.
    function automatic logic [6:0] inc_ms(input logic [2:0] d1, input logic [3:0] d0);
        if (d1 > 3'd5 || (d1 == 3'd5 && d0 >= 4'd9))
            return 7'd0;
        else if (d0 >= 4'd9)
            return {d1 + 3'd1, 4'd0};
        else
            return {d1, d0 + 4'd1};
    endfunction

    // Hours step: anything at or above 23 wraps to 00.
    function automatic logic [5:0] inc_hr(input logic [1:0] d1, input logic [3:0] d0);
        if (d1 > 2'd2 || (d1 == 2'd2 && d0 >= 4'd3))
            return 6'd0;
        else if (d0 >= 4'd9)
            return {d1 + 2'd1, 4'd0};
        else
            return {d1, d0 + 4'd1};
    endfunction

    assign mode_press = btn_mode & ~mode_prev;
    assign inc_press  = btn_inc & ~inc_prev;
    assign in_set     = (state == SET_H) || (state == SET_M) || (state == SET_S);
    assign rpt_fire   = in_set && btn_inc && !inc_press &&
                        (rpt_cnt == (repeating ? RPT_CYC - 32'd1 : HOLD_CYC - 32'd1));
    assign inc_fire   = in_set && (inc_press || rpt_fire) && !mode_press;
    assign en         = tick && (state == RUN);

    always_comb begin
        next_state = state;
        sel        = 2'd0;
        case (state)
            RUN:     if (mode_press) next_state = SET_H;
            SET_H: begin
                sel = 2'd1;
                if (mode_press) next_state = SET_M;
            end
            SET_M: begin
                sel = 2'd2;
                if (mode_press) next_state = SET_S;
            end
            SET_S: begin
                sel = 2'd3;
                if (mode_press) next_state = COMMIT;
            end
            COMMIT:  next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
            load      <= 1'b0;
            blink     <= 1'b0;
        end else begin
            state     <= next_state;
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
            load      <= (next_state == COMMIT);
            if ((state == RUN && next_state == SET_H) ||
                next_state == RUN || next_state == COMMIT)
                blink <= 1'b0;
            else if (in_set && tick)
                blink <= ~blink;
        end
    end

    // Hold phase counts to HOLD_CYC, then the repeat phase restarts every RPT_CYC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= 32'd0;
            repeating <= 1'b0;
        end else if (!in_set || !btn_inc || inc_press || mode_press) begin
            rpt_cnt   <= 32'd0;
            repeating <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= 32'd0;
            repeating <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {hd1, hd0} <= 6'd0;
            {md1, md0} <= 7'd0;
            {sd1, sd0} <= 7'd0;
        end else if (state == RUN && mode_press) begin
            {hd1, hd0} <= {hq1, hq0};
            {md1, md0} <= {mq1, mq0};
            {sd1, sd0} <= {sq1, sq0};
        end else if (inc_fire) begin
            case (state)
                SET_H:   {hd1, hd0} <= inc_hr(hd1, hd0);
                SET_M:   {md1, md0} <= inc_ms(md1, md0);
                SET_S:   {sd1, sd0} <= inc_ms(sd1, sd0);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - table-driven scoreboard bench for clock_set_ctrl
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, tick, btn_mode, btn_inc;
    logic [3:0] sq0, mq0, hq0, sd0, md0, hd0;
    logic [2:0] sq1, mq1, sd1, md1;
    logic [1:0] hq1, hd1, sel;
    logic       en, load, blink;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic mode, inc, tick;
        int   in_h, in_m, in_s;
        logic exp_en, exp_load;
        int   exp_sel;
        logic exp_blink;
        int   exp_h, exp_m, exp_s;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   cin_h, cin_m, cin_s;
    int   eh, em, es;

    always #5 clk = ~clk;

    clock_set_ctrl #(.HOLD_CYC(32'd8), .RPT_CYC(32'd4)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sq0(sq0), .sq1(sq1), .mq0(mq0), .mq1(mq1), .hq0(hq0), .hq1(hq1),
        .en(en), .load(load), .sd0(sd0), .sd1(sd1), .md0(md0), .md1(md1),
        .hd0(hd0), .hd1(hd1), .sel(sel), .blink(blink)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic m, input logic i, input logic t, input logic e_en,
                       input logic e_ld, input int e_sel, input logic e_bl,
                       input int h, input int mi, input int s);
        vec_t v;
        v.mode = m; v.inc = i; v.tick = t;
        v.in_h = cin_h; v.in_m = cin_m; v.in_s = cin_s;
        v.exp_en = e_en; v.exp_load = e_ld; v.exp_sel = e_sel; v.exp_blink = e_bl;
        v.exp_h = h; v.exp_m = mi; v.exp_s = s;
        vecs.push_back(v);
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        btn_mode = v.mode; btn_inc = v.inc; tick = v.tick;
        hq1 = 2'(v.in_h / 10); hq0 = 4'(v.in_h % 10);
        mq1 = 3'(v.in_m / 10); mq0 = 4'(v.in_m % 10);
        sq1 = 3'(v.in_s / 10); sq0 = 4'(v.in_s % 10);
        #1;
        chk($sformatf("en[%0d]", idx), int'(en), int'(v.exp_en));
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("load[%0d]", idx), int'(load), int'(e.exp_load));
        if (e.exp_sel >= 0) chk($sformatf("sel[%0d]", idx), int'(sel), e.exp_sel);
        chk($sformatf("blink[%0d]", idx), int'(blink), int'(e.exp_blink));
        chk($sformatf("hour[%0d]", idx), int'(hd1) * 10 + int'(hd0), e.exp_h);
        chk($sformatf("min[%0d]", idx), int'(md1) * 10 + int'(md0), e.exp_m);
        chk($sformatf("sec[%0d]", idx), int'(sd1) * 10 + int'(sd0), e.exp_s);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        {hq1, hq0, mq1, mq0, sq1, sq0} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", int'(en), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_blink", int'(blink), 0);
        chk("rst_edit", int'({hd1, hd0, md1, md0, sd1, sd0}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: run mode passes tick straight to en
        cin_h = 0; cin_m = 0; cin_s = 0;
        for (int k = 0; k < 6; k++) add(0, 0, k[0] == 1'b0, k[0] == 1'b0, 0, 0, 0, 0, 0, 0);

        // T2: capture 12:34:56, frozen counter, blink on ticks, hour/minute edits
        cin_h = 12; cin_m = 34; cin_s = 56;
        add(1, 0, 1, 1, 0, 1, 0, 12, 34, 56);
        add(0, 0, 1, 0, 0, 1, 1, 12, 34, 56);
        add(0, 0, 1, 0, 0, 1, 0, 12, 34, 56);
        eh = 12; em = 34; es = 56;
        for (int k = 0; k < 12; k++) begin
            eh = (eh + 1) % 24;
            add(0, 1, 0, 0, 0, 1, 0, eh, em, es);
            add(0, 0, 0, 0, 0, 1, 0, eh, em, es);
        end
        add(1, 0, 0, 0, 0, 2, 0, eh, em, es);
        add(0, 0, 0, 0, 0, 2, 0, eh, em, es);
        for (int k = 0; k < 26; k++) begin
            em = (em + 1) % 60;
            add(0, 1, 0, 0, 0, 2, 0, eh, em, es);
            add(0, 0, 0, 0, 0, 2, 0, eh, em, es);
        end

        // T3: seconds edit and commit
        add(1, 0, 0, 0, 0, 3, 0, eh, em, es);
        add(0, 0, 0, 0, 0, 3, 0, eh, em, es);
        for (int k = 0; k < 4; k++) begin
            es = (es + 1) % 60;
            add(0, 1, 0, 0, 0, 3, 0, eh, em, es);
            add(0, 0, 0, 0, 0, 3, 0, eh, em, es);
        end
        add(1, 0, 0, 0, 1, -1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

        // T4: auto-repeat from 58 minutes, then a commit
        cin_h = 9; cin_m = 58; cin_s = 56;
        add(1, 0, 0, 0, 0, 1, 0, 9, 58, 56);
        add(0, 0, 0, 0, 0, 1, 0, 9, 58, 56);
        add(1, 0, 0, 0, 0, 2, 0, 9, 58, 56);
        add(0, 0, 0, 0, 0, 2, 0, 9, 58, 56);
        em = 58;
        for (int k = 0; k < 20; k++) begin
            if (k == 0 || k == 8 || k == 12 || k == 16) em = (em + 1) % 60;
            add(0, 1, 0, 0, 0, 2, 0, 9, em, 56);
        end
        for (int k = 0; k < 6; k++) add(0, 0, 0, 0, 0, 2, 0, 9, em, 56);
        add(1, 0, 0, 0, 0, 3, 0, 9, 2, 56);
        add(0, 0, 0, 0, 0, 3, 0, 9, 2, 56);
        add(1, 0, 0, 0, 1, -1, 0, 9, 2, 56);
        add(0, 0, 0, 0, 0, 0, 0, 9, 2, 56);

        // T5: MODE and INC together, MODE wins
        add(1, 0, 0, 0, 0, 1, 0, 9, 58, 56);
        add(0, 0, 0, 0, 0, 1, 0, 9, 58, 56);
        add(1, 1, 0, 0, 0, 2, 0, 9, 58, 56);
        add(0, 0, 0, 0, 0, 2, 0, 9, 58, 56);
        add(0, 1, 0, 0, 0, 2, 0, 9, 59, 56);
        add(0, 0, 0, 0, 0, 2, 0, 9, 59, 56);
        add(0, 1, 0, 0, 0, 2, 0, 9, 0, 56);
        add(0, 0, 0, 0, 0, 2, 0, 9, 0, 56);
        add(0, 1, 0, 0, 0, 2, 0, 9, 1, 56);
        add(0, 0, 0, 0, 0, 2, 0, 9, 1, 56);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // T6: asynchronous reset mid-edit aborts without a load
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_sel", int'(sel), 0);
        chk("t6_load", int'(load), 0);
        chk("t6_edit", int'({hd1, hd0, md1, md0, sd1, sd0}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tick = k[0];
            #1;
            chk($sformatf("t6_en[%0d]", k), int'(en), int'(k[0]));
            @(posedge clk);
            #1;
            chk($sformatf("t6_load[%0d]", k), int'(load), 0);
            chk($sformatf("t6_sel[%0d]", k), int'(sel), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
